// File: rtl/instr_decode_stage.sv
// instr_decode_stage: buffered MIPS instruction decode stage.
// {instr, pc} beats enter a small FIFO over valid/ready. The head entry is
// split into R/I/J fields, extended immediates, PC+4, jump target and class.
// Every decoded output reads zero while the FIFO is empty, so the stage presents a NOP.
module instr_decode_stage #(
   parameter int PC_WIDTH = 32,
   parameter int XLEN     = 32,
   parameter int DEPTH    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [5:0]                 opcode,
   output logic [4:0]                 rs,
   output logic [4:0]                 rt,
   output logic [4:0]                 rd,
   output logic [4:0]                 shamt,
   output logic [5:0]                 funct,
   output logic [15:0]                imm,
   output logic [XLEN-1:0]            imm_sext,
   output logic [XLEN-1:0]            imm_zext,
   output logic [25:0]                address_j,
   output logic [PC_WIDTH-1:0]        pc_plus4,
   output logic [PC_WIDTH-1:0]        jump_target,
   output logic [1:0]                 instr_type,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      CLS_R   = 2'b00,
      CLS_I   = 2'b01,
      CLS_J   = 2'b10,
      CLS_UNU = 2'b11
   } instr_cls_e;

   logic [31:0]         r_instr_mem [DEPTH];
   logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
   logic [AW-1:0]       r_rd_ptr;
   logic [AW-1:0]       r_wr_ptr;
   logic [CW-1:0]       r_count;

   logic                w_push;
   logic                w_pop;
   logic [31:0]         w_head_instr;
   logic [PC_WIDTH-1:0] w_head_pc;
   logic [PC_WIDTH-1:0] w_pc_plus4;
   logic [15:0]         w_imm;
   logic [25:0]         w_addr_j;
   instr_cls_e          w_cls;

   // Handshake status derives only from registered occupancy, so there is no
   // combinational path from out_ready to in_ready.
   assign in_ready  = (r_count < CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign count     = r_count;

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   // Entry storage: written on accepted pushes; a push during reset or flush is dropped.
   always_ff @(posedge clk) begin
      if (w_push && !reset && !flush) begin
         r_instr_mem[r_wr_ptr] <= in_instr;
         r_pc_mem[r_wr_ptr]    <= in_pc;
      end
   end

   // Pointer and occupancy control; reset outranks flush, flush outranks handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head entry, forced to zero while empty so all decoded fields read as a NOP.
   always_comb begin
      w_head_instr = '0;
      w_head_pc    = '0;
      w_pc_plus4   = '0;
      if (out_valid) begin
         w_head_instr = r_instr_mem[r_rd_ptr];
         w_head_pc    = r_pc_mem[r_rd_ptr];
         w_pc_plus4   = w_head_pc + PC_WIDTH'(4);
      end
   end

   assign w_imm    = w_head_instr[15:0];
   assign w_addr_j = w_head_instr[25:0];

   assign opcode    = w_head_instr[31:26];
   assign rs        = w_head_instr[25:21];
   assign rt        = w_head_instr[20:16];
   assign rd        = w_head_instr[15:11];
   assign shamt     = w_head_instr[10:6];
   assign funct     = w_head_instr[5:0];
   assign imm       = w_imm;
   assign address_j = w_addr_j;
   assign imm_sext  = XLEN'($signed(w_imm));
   assign imm_zext  = XLEN'(w_imm);
   assign pc_plus4  = w_pc_plus4;

   // Jump target formed at 32 bits, then truncated so narrow PC builds
   // (PC_WIDTH = 28) keep only the shifted jump address.
   assign jump_target = PC_WIDTH'((32'(w_pc_plus4) & 32'hF000_0000) |
                                  {4'b0000, w_addr_j, 2'b00});

   // Instruction class from the opcode; an empty stage reports R (all zeros).
   always_comb begin
      w_cls = CLS_R;
      if (out_valid) begin
         unique case (w_head_instr[31:26])
            6'h00:        w_cls = CLS_R;
            6'h02, 6'h03: w_cls = CLS_J;
            default:      w_cls = CLS_I;
         endcase
      end
   end

   assign instr_type = w_cls;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the decode stage.
module tb_instr_decode_stage;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic        clk;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic          in_ready, out_valid;
   logic [5:0]    opcode, funct;
   logic [4:0]    rs, rt, rd, shamt;
   logic [15:0]   imm;
   logic [31:0]   imm_sext, imm_zext, pc_plus4, jump_target;
   logic [25:0]   address_j;
   logic [1:0]    instr_type;
   logic [CW-1:0] count;

   // narrow-PC build outputs
   logic          n_in_ready, n_out_valid;
   logic [5:0]    n_opcode, n_funct;
   logic [4:0]    n_rs, n_rt, n_rd, n_shamt;
   logic [15:0]   n_imm;
   logic [31:0]   n_imm_sext, n_imm_zext;
   logic [25:0]   n_address_j;
   logic [27:0]   n_pc_plus4, n_jump_target;
   logic [1:0]    n_instr_type;
   logic [CW-1:0] n_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] q_instr[$];
   logic [31:0] q_pc[$];
   bit          model_known = 0;

   instr_decode_stage #(.PC_WIDTH(32), .XLEN(32), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .imm_sext(imm_sext), .imm_zext(imm_zext),
      .address_j(address_j), .pc_plus4(pc_plus4), .jump_target(jump_target),
      .instr_type(instr_type), .count(count)
   );

   instr_decode_stage #(.PC_WIDTH(28), .XLEN(32), .DEPTH(DEPTH)) u_dut28 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready),
      .in_instr(in_instr), .in_pc(in_pc[27:0]),
      .out_valid(n_out_valid), .out_ready(out_ready),
      .opcode(n_opcode), .rs(n_rs), .rt(n_rt), .rd(n_rd), .shamt(n_shamt), .funct(n_funct),
      .imm(n_imm), .imm_sext(n_imm_sext), .imm_zext(n_imm_zext),
      .address_j(n_address_j), .pc_plus4(n_pc_plus4), .jump_target(n_jump_target),
      .instr_type(n_instr_type), .count(n_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's view of the head entry.
   task automatic check_all();
      bit          v;
      logic [31:0] i, p, op, immv, aj, p4, jt, ty;
      v    = (q_instr.size() != 0);
      i    = v ? q_instr[0] : 32'd0;
      p    = v ? q_pc[0]    : 32'd0;
      op   = i >> 26;
      immv = i % 65536;
      aj   = i % (1 << 26);
      p4   = v ? p + 32'd4 : 32'd0;
      jt   = v ? ((p4 / 32'h1000_0000) * 32'h1000_0000) + aj * 4 : 32'd0;
      if (!v)                      ty = 0;
      else if (op == 0)            ty = 0;
      else if (op == 2 || op == 3) ty = 2;
      else                         ty = 1;
      chk("out_valid", out_valid, v);
      chk("in_ready", in_ready, q_instr.size() < DEPTH);
      chk("count", count, q_instr.size());
      chk("opcode", opcode, op);
      chk("rs", rs, (i >> 21) % 32);
      chk("rt", rt, (i >> 16) % 32);
      chk("rd", rd, (i >> 11) % 32);
      chk("shamt", shamt, (i >> 6) % 32);
      chk("funct", funct, i % 64);
      chk("imm", imm, immv);
      chk("imm_sext", imm_sext, (immv >= 32768) ? immv + 32'hFFFF_0000 : immv);
      chk("imm_zext", imm_zext, immv);
      chk("address_j", address_j, aj);
      chk("pc_plus4", pc_plus4, p4);
      chk("jump_target", jump_target, jt);
      chk("instr_type", instr_type, ty);
      chk("n_count", n_count, q_instr.size());
      chk("n_pc_plus4", n_pc_plus4, p4 % (1 << 28));
      chk("n_jump_target", n_jump_target, v ? (aj * 4) % (1 << 28) : 0);
   endtask

   // One clock cycle: drive, check pre-edge state, apply model at the edge.
   task automatic cycle(input logic r, input logic f, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
      bit do_push, do_pop;
      reset = r; flush = f; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
      #2;
      if (model_known) check_all();
      do_push = v && (q_instr.size() < DEPTH);
      do_pop  = ordy && (q_instr.size() != 0);
      @(posedge clk);
      if (r || f) begin
         q_instr.delete();
         q_pc.delete();
         model_known = 1;
      end else begin
         if (do_pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
         end
         if (do_push) begin
            q_instr.push_back(ins);
            q_pc.push_back(pc);
         end
      end
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 3))
         0: w[31:26] = 6'h00;
         1: w[31:26] = 6'h02;
         2: w[31:26] = 6'h03;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;

      // Scenario 1: reset, then a single R-type beat.
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      cycle(0, 0, 1, 32'h012A4020, 32'h0040_0000, 1);
      chk("s1_opcode", opcode, 0);
      chk("s1_rs", rs, 9);
      chk("s1_rt", rt, 10);
      chk("s1_rd", rd, 8);
      chk("s1_funct", funct, 6'h20);
      chk("s1_type", instr_type, 2'b00);
      chk("s1_pc4", pc_plus4, 32'h0040_0004);
      cycle(0, 0, 0, 0, 0, 1);
      chk("s1_count_after_pop", count, 0);

      // Scenario 2: I-type immediate extension.
      cycle(0, 0, 1, 32'h2128FFFC, 32'h0040_0010, 0);
      chk("s2_imm", imm, 16'hFFFC);
      chk("s2_sext", imm_sext, 32'hFFFF_FFFC);
      chk("s2_zext", imm_zext, 32'h0000_FFFC);
      chk("s2_type", instr_type, 2'b01);
      chk("s2_rt", rt, 8);
      cycle(0, 0, 0, 0, 0, 1);

      // Scenario 3: J-type target on both PC widths.
      cycle(0, 0, 1, 32'h0C100010, 32'h0040_0020, 0);
      chk("s3_addr", address_j, 26'h0100010);
      chk("s3_type", instr_type, 2'b10);
      chk("s3_jt", jump_target, 32'h0040_0040);
      chk("s3_jt28", n_jump_target, 28'h040_0040);
      cycle(0, 0, 0, 0, 0, 1);

      // Scenario 4: back-pressure, third beat held upstream.
      cycle(0, 0, 1, 32'h11111111, 32'h100, 0);
      cycle(0, 0, 1, 32'h22222222, 32'h104, 0);
      chk("s4_full_count", count, 2);
      chk("s4_full_ready", in_ready, 0);
      cycle(0, 0, 1, 32'h33333333, 32'h108, 0);
      chk("s4_held_count", count, 2);
      cycle(0, 0, 1, 32'h33333333, 32'h108, 1);   // pop while full: no push
      chk("s4_ready_rise", in_ready, 1);
      chk("s4_count1", count, 1);
      cycle(0, 0, 1, 32'h33333333, 32'h108, 1);   // push+pop at count 1
      chk("s4_count_hold", count, 1);
      chk("s4_head", rt, 5'h13);
      cycle(0, 0, 0, 0, 0, 1);

      // Scenario 5: flush with concurrent push and pop.
      cycle(0, 0, 1, 32'h8C440008, 32'h200, 0);
      cycle(0, 0, 1, 32'h08000040, 32'h204, 0);
      cycle(0, 1, 1, 32'h00000000, 32'h208, 1);
      chk("s5_count", count, 0);
      chk("s5_out_valid", out_valid, 0);
      chk("s5_in_ready", in_ready, 1);
      chk("s5_opcode", opcode, 0);
      chk("s5_imm", imm, 0);
      chk("s5_pc4", pc_plus4, 0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1);

      // Scenario 6: reset and flush together while full.
      cycle(0, 0, 1, 32'hAAAA5555, 32'h300, 0);
      cycle(0, 0, 1, 32'h5555AAAA, 32'h304, 0);
      cycle(1, 1, 1, 32'h0C000001, 32'h308, 1);
      chk("s6_count", count, 0);
      chk("s6_in_ready", in_ready, 1);
      chk("s6_out_valid", out_valid, 0);
      chk("s6_jt", jump_target, 0);

      // Random traffic with occasional flush and reset.
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) != 0),
               rand_instr(),
               $urandom,
               ($urandom_range(0, 2) != 0));
      end
      cycle(0, 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Buffered instruction decode stage between instruction memory/fetch and the register file/control unit.
- Accepts {instruction, pc} beats over a valid/ready handshake into a parametrised FIFO.
- Presents the head entry split into MIPS R/I/J fields, plus extended immediates, PC+4, jump target and an instruction class.
- Supports downstream stalls (out_ready low) and pipeline flushes.

Parameters:
- PC_WIDTH, 32: width of pc, pc_plus4 and jump_target; legal range 28..32.
- XLEN, 32: width of the extended immediate outputs; must be at least 16.
- DEPTH, 2: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  instruction word
- in_pc  in  PC_WIDTH  address of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- opcode  out  6  head[31:26]
- rs  out  5  head[25:21]
- rt  out  5  head[20:16]
- rd  out  5  head[15:11]
- shamt  out  5  head[10:6]
- funct  out  6  head[5:0]
- imm  out  16  head[15:0]
- imm_sext  out  XLEN  imm sign-extended
- imm_zext  out  XLEN  imm zero-extended
- address_j  out  26  head[25:0]
- pc_plus4  out  PC_WIDTH  head pc + 4, modulo 2^PC_WIDTH
- jump_target  out  PC_WIDTH  {pc_plus4[PC_WIDTH-1:28], address_j, 2'b00}, truncated to PC_WIDTH
- instr_type  out  2  00 = R, 01 = I, 10 = J, 11 unused
- count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: rd_ptr, wr_ptr and count clear to 0, so out_valid = 0 and in_ready = 1.
  - Every decoded output reads 0 while empty, so the stage presents a NOP.
  - Reset has priority over flush and over all handshakes.
  - A reset mid-stream drops all entries; nothing accepted in the reset cycle is stored.
- Handshake and storage:
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - in_ready = (count < DEPTH). It is registered-state only and does not depend on out_ready, so there is no combinational ready path. When the FIFO is full, in_ready stays low even if a pop occurs in the same cycle.
  - out_valid = (count != 0).
  - Storage is registered, {instr, pc} per entry.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
- Latency:
  - A beat pushed in cycle N is visible at the outputs in cycle N+1 if the FIFO was empty, otherwise once it reaches the head.
  - There is no combinational bypass from in_instr to the outputs.
- Decode:
  - All field outputs are combinational from the head entry and are gated to 0 when out_valid = 0.
  - Outputs remain stable while out_valid && !out_ready.
  - imm_sext replicates imm[15] into bits XLEN-1..16; imm_zext fills those bits with 0.
  - instr_type: opcode 6'h00 -> 00; opcode 6'h02 or 6'h03 -> 10; all other opcodes -> 01.
- Flush:
  - Takes effect at the next edge: count = 0 and pointers = 0.
  - A push and a pop occurring in the flush cycle are both discarded, and the popped beat is treated as not delivered.
  - in_ready stays at its pre-flush value during the flush cycle.
  - One cycle after flush, out_valid = 0 and in_ready = 1.
- Full/empty boundaries:
  - Empty + pop request: no action, out_ready is ignored.
  - Full + push request: in_ready = 0, so upstream holds the beat.
- Ordering: strict FIFO order; no entry is reordered or duplicated.

Test Plan:
1. Reset then single beat: assert reset for 2 cycles, release. Push in_instr = 32'h012A4020 (add $8,$9,$10), pc = 32'h00400000, with out_ready = 1. Required next cycle: opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 6'h20, instr_type 00, pc_plus4 32'h00400004. Count returns to 0 one cycle after the pop.
2. I-type extension: push 32'h2128FFFC (addi $8,$9,-4). Required: imm 16'hFFFC, imm_sext 32'hFFFFFFFC, imm_zext 32'h0000FFFC, instr_type 01, rt 8.
3. J-type target: push 32'h0C100010 (jal) at pc 32'h00400020. Required: address_j 26'h0100010, instr_type 10, jump_target 32'h00400040.
4. Back-pressure with DEPTH = 2:
   - Hold out_ready = 0 and push 3 beats. Required: in_ready drops after the 2nd push and count = 2; the 3rd beat is held upstream.
   - Then raise out_ready. Required: beats emerge in order with no loss and no duplication, and in_ready rises one cycle after the first pop.
   - Simultaneous push/pop at count = 1 keeps count at 1.
5. Flush mid-stream: count = 2, assert flush with in_valid = 1 and out_ready = 1. Required next cycle: count 0, out_valid 0, all fields 0, in_ready 1, and neither beat appears later.
6. Reset over flush: assert reset and flush together while the FIFO is full with in_valid = 1. Required: empty state as after a plain reset; the PC_WIDTH = 28 build passes scenario 3 with jump_target 28'h0400040.
